// File: rtl/jump_control_sequencer_if.sv
// Control bundle between the jump/branch sequencer and the datapath.
// master = sequencer side (drives strobes), slave = datapath/stimulus side.
interface jump_control_sequencer_if #(
  parameter int OPC_W = 5
);
  logic             Run;
  logic             Stop;
  logic [OPC_W-1:0] opcode;
  logic             CON;
  logic             mem_ready;

  logic PCout;
  logic MARin;
  logic Read;
  logic MDRin;
  logic PCin;
  logic IncPC;
  logic MDRout;
  logic IRin;

  logic Gra;
  logic Rout;
  logic Rin;
  logic CONin;
  logic Yin;
  logic Zin;
  logic Cout;
  logic ZLOout;

  logic LinkSel;
  logic AluAdd;

  logic [3:0] step;
  logic       busy;
  logic       halted;
  logic       instr_done;
  logic       illegal;
  logic       mem_timeout;

  modport master (
    input  Run, Stop, opcode, CON, mem_ready,
    output PCout, MARin, Read, MDRin, PCin, IncPC, MDRout, IRin,
    output Gra, Rout, Rin, CONin, Yin, Zin, Cout, ZLOout,
    output LinkSel, AluAdd,
    output step, busy, halted, instr_done, illegal, mem_timeout
  );

  modport slave (
    output Run, Stop, opcode, CON, mem_ready,
    input  PCout, MARin, Read, MDRin, PCin, IncPC, MDRout, IRin,
    input  Gra, Rout, Rin, CONin, Yin, Zin, Cout, ZLOout,
    input  LinkSel, AluAdd,
    input  step, busy, halted, instr_done, illegal, mem_timeout
  );
endinterface

// File: rtl/jump_control_sequencer.sv
// Hardwired fetch/execute control-step sequencer for jr, jal, branch, nop and halt.
// Strobes are Moore-decoded from the state; only mem_ready, CON and opcode gate them.
//
//   state  | meaning
//   IDLE   | no strobes, waiting for Run
//   T0     | PC -> MAR
//   T1     | memory read; waits for mem_ready, PC+1 on completion
//   T2     | MDR -> IR
//   T3     | decode and first execute step
//   T4     | jal: jump to Ra / br: PC -> Y
//   T5     | br: Z <- Y + C
//   T6     | br: PC <- Z when CON
//   HALTED | halt executed; left only through Reset
module jump_control_sequencer #(
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] BR_OPC   = OPC_W'(5'b10010),
  parameter logic [OPC_W-1:0] JR_OPC   = OPC_W'(5'b10011),
  parameter logic [OPC_W-1:0] JAL_OPC  = OPC_W'(5'b10100),
  parameter logic [OPC_W-1:0] NOP_OPC  = OPC_W'(5'b11001),
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(5'b11010),
  parameter int               MAX_WAIT = 15,
  parameter int               WAIT_W   = 4
) (
  input logic                       Clock,
  input logic                       Reset,
  jump_control_sequencer_if.master  ctl
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                br_q, br_d;
  logic                timeout_q, timeout_d;
  state_t              boundary_next;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      br_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      br_q      <= br_d;
      timeout_q <= timeout_d;
    end
  end

  // Stop is only honoured on the step that completes an instruction.
  assign boundary_next = ctl.Stop ? S_IDLE : S_T0;

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    br_d       = br_q;
    timeout_d  = timeout_q;

    ctl.PCout      = 1'b0;
    ctl.MARin      = 1'b0;
    ctl.Read       = 1'b0;
    ctl.MDRin      = 1'b0;
    ctl.PCin       = 1'b0;
    ctl.IncPC      = 1'b0;
    ctl.MDRout     = 1'b0;
    ctl.IRin       = 1'b0;
    ctl.Gra        = 1'b0;
    ctl.Rout       = 1'b0;
    ctl.Rin        = 1'b0;
    ctl.CONin      = 1'b0;
    ctl.Yin        = 1'b0;
    ctl.Zin        = 1'b0;
    ctl.Cout       = 1'b0;
    ctl.ZLOout     = 1'b0;
    ctl.LinkSel    = 1'b0;
    ctl.AluAdd     = 1'b0;
    ctl.instr_done = 1'b0;
    ctl.illegal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctl.Run) state_d = S_T0;
      end

      S_T0: begin
        ctl.PCout = 1'b1;
        ctl.MARin = 1'b1;
        state_d   = S_T1;
      end

      S_T1: begin
        ctl.Read  = 1'b1;
        ctl.MDRin = 1'b1;
        if (ctl.mem_ready) begin
          ctl.PCin  = 1'b1;
          ctl.IncPC = 1'b1;
          state_d   = S_T2;
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          // Abandon the fetch with PC untouched; the flag stays until Reset.
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_T2: begin
        ctl.MDRout = 1'b1;
        ctl.IRin   = 1'b1;
        state_d    = S_T3;
      end

      S_T3: begin
        br_d = (ctl.opcode == BR_OPC);
        if (ctl.opcode == JR_OPC) begin
          ctl.Gra        = 1'b1;
          ctl.Rout       = 1'b1;
          ctl.PCin       = 1'b1;
          ctl.instr_done = 1'b1;
          state_d        = boundary_next;
        end else if (ctl.opcode == JAL_OPC) begin
          ctl.PCout   = 1'b1;
          ctl.Rin     = 1'b1;
          ctl.LinkSel = 1'b1;
          state_d     = S_T4;
        end else if (ctl.opcode == BR_OPC) begin
          ctl.Gra   = 1'b1;
          ctl.Rout  = 1'b1;
          ctl.CONin = 1'b1;
          state_d   = S_T4;
        end else if (ctl.opcode == NOP_OPC) begin
          ctl.instr_done = 1'b1;
          state_d        = boundary_next;
        end else if (ctl.opcode == HALT_OPC) begin
          // Halt takes priority over a coincident Stop.
          ctl.instr_done = 1'b1;
          state_d        = S_HALTED;
        end else begin
          ctl.illegal    = 1'b1;
          ctl.instr_done = 1'b1;
          state_d        = boundary_next;
        end
      end

      S_T4: begin
        if (br_q) begin
          ctl.PCout = 1'b1;
          ctl.Yin   = 1'b1;
          state_d   = S_T5;
        end else begin
          ctl.Gra        = 1'b1;
          ctl.Rout       = 1'b1;
          ctl.PCin       = 1'b1;
          ctl.instr_done = 1'b1;
          state_d        = boundary_next;
        end
      end

      S_T5: begin
        ctl.Cout   = 1'b1;
        ctl.AluAdd = 1'b1;
        ctl.Zin    = 1'b1;
        state_d    = S_T6;
      end

      S_T6: begin
        ctl.ZLOout     = 1'b1;
        ctl.PCin       = ctl.CON;
        ctl.instr_done = 1'b1;
        state_d        = boundary_next;
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ctl.step        = state_q;
  assign ctl.busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign ctl.halted      = (state_q == S_HALTED);
  assign ctl.mem_timeout = timeout_q;

endmodule

// File: tb/tb_jump_control_sequencer.sv
// Directed bench for jump_control_sequencer with a tiny PC/R15/Y/Z datapath model.
module tb_jump_control_sequencer;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3, ST_T3 = 4'd4;
  localparam logic [3:0] ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7, ST_HALTED = 4'd8;

  localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10011, OP_JAL = 5'b10100;
  localparam logic [4:0] OP_NOP = 5'b11001, OP_HALT = 5'b11010, OP_BAD = 5'b00111;

  localparam logic [17:0] M_PCOUT  = 18'h20000, M_MARIN  = 18'h10000, M_READ   = 18'h08000;
  localparam logic [17:0] M_MDRIN  = 18'h04000, M_PCIN   = 18'h02000, M_INCPC  = 18'h01000;
  localparam logic [17:0] M_MDROUT = 18'h00800, M_IRIN   = 18'h00400, M_GRA    = 18'h00200;
  localparam logic [17:0] M_ROUT   = 18'h00100, M_RIN    = 18'h00080, M_CONIN  = 18'h00040;
  localparam logic [17:0] M_YIN    = 18'h00020, M_ZIN    = 18'h00010, M_COUT   = 18'h00008;
  localparam logic [17:0] M_ZLOOUT = 18'h00004, M_LINK   = 18'h00002, M_ALUADD = 18'h00001;

  localparam logic [17:0] S_FETCH0 = M_PCOUT | M_MARIN;
  localparam logic [17:0] S_WAIT   = M_READ | M_MDRIN;
  localparam logic [17:0] S_FETCH1 = M_READ | M_MDRIN | M_PCIN | M_INCPC;
  localparam logic [17:0] S_FETCH2 = M_MDROUT | M_IRIN;
  localparam logic [31:0] BR_OFF   = 32'd4;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  jump_control_sequencer_if #(.OPC_W(5)) bus ();

  jump_control_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .ctl   (bus)
  );

  int checks = 0;
  int errors = 0;

  wire [17:0] strb = {bus.PCout, bus.MARin, bus.Read, bus.MDRin, bus.PCin, bus.IncPC,
                      bus.MDRout, bus.IRin, bus.Gra, bus.Rout, bus.Rin, bus.CONin,
                      bus.Yin, bus.Zin, bus.Cout, bus.ZLOout, bus.LinkSel, bus.AluAdd};
  wire [4:0] drivers = {bus.PCout, bus.Rout, bus.MDRout, bus.ZLOout, bus.Cout};

  // Datapath model: PC, link register, Y and Z, with Ra supplied by the bench.
  logic [31:0] pc = '0, r15 = '0, y_reg = '0, z_reg = '0;
  logic [31:0] ra_val = '0, pc_init = '0;
  logic        pc_set = 1'b0;

  always @(posedge Clock) begin
    if (pc_set) pc <= pc_init;
    else if (bus.PCin) begin
      if (bus.IncPC)       pc <= pc + 32'd1;
      else if (bus.Rout)   pc <= ra_val;
      else if (bus.ZLOout) pc <= z_reg;
    end
    if (bus.Rin && bus.LinkSel && bus.PCout) r15 <= pc;
    if (bus.Yin && bus.PCout) y_reg <= pc;
    if (bus.Zin && bus.Cout && bus.AluAdd) z_reg <= y_reg + BR_OFF;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge Clock)
    if (!Reset) check_eq("bus_excl", ($countones(drivers) <= 1) ? 32'd1 : 32'd0, 32'd1);

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [17:0] s,
                            input logic done, input logic ill);
    @(negedge Clock);
    check_eq({tag, ".step"}, 32'(bus.step), 32'(st));
    check_eq({tag, ".strb"}, 32'(strb), 32'(s));
    check_eq({tag, ".done"}, 32'(bus.instr_done), 32'(done));
    check_eq({tag, ".ill"},  32'(bus.illegal), 32'(ill));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    bus.Run = 1'b0; bus.Stop = 1'b0; bus.opcode = 5'b0; bus.CON = 1'b0; bus.mem_ready = 1'b0;
    #3;
    check_eq("rst.step", 32'(bus.step), 32'(ST_IDLE));
    check_eq("rst.strb", 32'(strb), 32'd0);
    check_eq("rst.busy", 32'(bus.busy), 32'd0);
    check_eq("rst.halted", 32'(bus.halted), 32'd0);
    check_eq("rst.tmo", 32'(bus.mem_timeout), 32'd0);
    check_eq("rst.done", 32'(bus.instr_done), 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    tick(); expect_cyc("idle_hold", ST_IDLE, '0, 0, 0);

    // jr R2 with R2=25
    bus.Run = 1'b1; bus.opcode = OP_JR; bus.mem_ready = 1'b1; ra_val = 32'd25;
    tick(); expect_cyc("jr.t0", ST_T0, S_FETCH0, 0, 0);
    check_eq("jr.busy", 32'(bus.busy), 32'd1);
    tick(); expect_cyc("jr.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("jr.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); expect_cyc("jr.t3", ST_T3, M_GRA | M_ROUT | M_PCIN, 1, 0);

    // jal from PC=13, target 40
    tick(); check_eq("jr.pc", pc, 32'd25);
    bus.opcode = OP_JAL; ra_val = 32'd40; pc_init = 32'd13; pc_set = 1'b1;
    expect_cyc("jal.t0", ST_T0, S_FETCH0, 0, 0);
    tick(); pc_set = 1'b0; check_eq("jal.pc0", pc, 32'd13);
    expect_cyc("jal.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("jal.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); expect_cyc("jal.t3", ST_T3, M_PCOUT | M_RIN | M_LINK, 0, 0);
    tick(); check_eq("jal.r15", r15, 32'd14);
    expect_cyc("jal.t4", ST_T4, M_GRA | M_ROUT | M_PCIN, 1, 0);

    // branch taken: CON low until T6
    tick(); check_eq("jal.pc", pc, 32'd40);
    bus.opcode = OP_BR; bus.CON = 1'b0;
    expect_cyc("brt.t0", ST_T0, S_FETCH0, 0, 0);
    tick(); expect_cyc("brt.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("brt.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); expect_cyc("brt.t3", ST_T3, M_GRA | M_ROUT | M_CONIN, 0, 0);
    tick(); expect_cyc("brt.t4", ST_T4, M_PCOUT | M_YIN, 0, 0);
    tick(); expect_cyc("brt.t5", ST_T5, M_COUT | M_ALUADD | M_ZIN, 0, 0);
    tick(); bus.CON = 1'b1;
    expect_cyc("brt.t6", ST_T6, M_ZLOOUT | M_PCIN, 1, 0);

    // branch not taken: CON high in T5, low in T6
    tick(); check_eq("brt.pc", pc, 32'd45);
    expect_cyc("brn.t0", ST_T0, S_FETCH0, 0, 0);
    tick(); expect_cyc("brn.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("brn.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); expect_cyc("brn.t3", ST_T3, M_GRA | M_ROUT | M_CONIN, 0, 0);
    tick(); expect_cyc("brn.t4", ST_T4, M_PCOUT | M_YIN, 0, 0);
    tick(); expect_cyc("brn.t5", ST_T5, M_COUT | M_ALUADD | M_ZIN, 0, 0);
    tick(); bus.CON = 1'b0;
    expect_cyc("brn.t6", ST_T6, M_ZLOOUT, 1, 0);

    // nop with mem_ready low for three T1 cycles
    tick(); check_eq("brn.pc", pc, 32'd46);
    bus.opcode = OP_NOP; bus.mem_ready = 1'b0;
    expect_cyc("wait.t0", ST_T0, S_FETCH0, 0, 0);
    tick(); expect_cyc("wait.t1a", ST_T1, S_WAIT, 0, 0);
    tick(); expect_cyc("wait.t1b", ST_T1, S_WAIT, 0, 0);
    tick(); expect_cyc("wait.t1c", ST_T1, S_WAIT, 0, 0);
    tick(); bus.mem_ready = 1'b1;
    expect_cyc("wait.t1d", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("wait.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); expect_cyc("nop.t3", ST_T3, '0, 1, 0);
    check_eq("wait.pc", pc, 32'd47);

    // timeout: mem_ready held low for 16 T1 cycles
    tick(); bus.mem_ready = 1'b0;
    expect_cyc("tmo.t0", ST_T0, S_FETCH0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick(); expect_cyc($sformatf("tmo.t1_%0d", i), ST_T1, S_WAIT, 0, 0);
    end
    check_eq("tmo.pre", 32'(bus.mem_timeout), 32'd0);
    tick(); bus.mem_ready = 1'b1; bus.opcode = OP_JR;
    expect_cyc("tmo.idle", ST_IDLE, '0, 0, 0);
    check_eq("tmo.flag", 32'(bus.mem_timeout), 32'd1);
    check_eq("tmo.pc", pc, 32'd47);

    // jr with Stop raised in T2: back to IDLE after T3
    tick(); expect_cyc("stop.t0", ST_T0, S_FETCH0, 0, 0);
    tick(); expect_cyc("stop.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); bus.Stop = 1'b1;
    expect_cyc("stop.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); expect_cyc("stop.t3", ST_T3, M_GRA | M_ROUT | M_PCIN, 1, 0);
    tick(); expect_cyc("stop.idle", ST_IDLE, '0, 0, 0);

    // illegal opcode; Stop held through fetch but dropped at the boundary
    bus.opcode = OP_BAD;
    tick(); expect_cyc("ill.t0", ST_T0, S_FETCH0, 0, 0);
    tick(); expect_cyc("ill.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("ill.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); bus.Stop = 1'b0;
    expect_cyc("ill.t3", ST_T3, '0, 1, 1);
    tick(); expect_cyc("ill.next", ST_T0, S_FETCH0, 0, 0);

    // halt with a coincident Stop
    bus.opcode = OP_HALT;
    tick(); expect_cyc("halt.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("halt.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); bus.Stop = 1'b1;
    expect_cyc("halt.t3", ST_T3, '0, 1, 0);
    tick(); bus.Stop = 1'b0;
    expect_cyc("halt.h0", ST_HALTED, '0, 0, 0);
    check_eq("halt.halted", 32'(bus.halted), 32'd1);
    check_eq("halt.busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    expect_cyc("halt.hold", ST_HALTED, '0, 0, 0);
    check_eq("halt.tmo", 32'(bus.mem_timeout), 32'd1);

    Reset = 1'b1;
    #1;
    check_eq("halt.rst_step", 32'(bus.step), 32'(ST_IDLE));
    check_eq("halt.rst_tmo", 32'(bus.mem_timeout), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // async reset in the middle of T5 of a branch
    bus.opcode = OP_BR;
    tick(); expect_cyc("rb.t0", ST_T0, S_FETCH0, 0, 0);
    tick(); expect_cyc("rb.t1", ST_T1, S_FETCH1, 0, 0);
    tick(); expect_cyc("rb.t2", ST_T2, S_FETCH2, 0, 0);
    tick(); expect_cyc("rb.t3", ST_T3, M_GRA | M_ROUT | M_CONIN, 0, 0);
    tick(); expect_cyc("rb.t4", ST_T4, M_PCOUT | M_YIN, 0, 0);
    tick(); expect_cyc("rb.t5", ST_T5, M_COUT | M_ALUADD | M_ZIN, 0, 0);
    #2 Reset = 1'b1;
    #1;
    check_eq("rb.rst_step", 32'(bus.step), 32'(ST_IDLE));
    check_eq("rb.rst_strb", 32'(strb), 32'd0);
    check_eq("rb.rst_busy", 32'(bus.busy), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    tick(); expect_cyc("rb.refetch_t0", ST_T0, S_FETCH0, 0, 0);
    tick(); expect_cyc("rb.refetch_t1", ST_T1, S_FETCH1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_control_sequencer.md
Name: jump_control_sequencer

Overview:
- Hardwired control-step sequencer for the datapath. Drives the fetch steps T0–T2 and the execute steps for the jump/branch class: jr, jal, conditional branch, nop and halt.
- Replaces hand-timed testbench strobes with a clocked state machine.
- Generalised over opcode encoding, memory wait tolerance and stop/halt modes.
- Sits beside the datapath; its outputs connect one-to-one to the datapath control inputs.

Parameters:
- OPC_W, 5, opcode width taken from IR[31:27].
- BR_OPC, 5'b10010, conditional branch opcode (condition evaluated by the CON logic).
- JR_OPC, 5'b10011, jump register opcode.
- JAL_OPC, 5'b10100, jump-and-link opcode.
- NOP_OPC, 5'b11001, no-operation opcode.
- HALT_OPC, 5'b11010, halt opcode.
- MAX_WAIT, 15, maximum cycles T1 waits for mem_ready before timeout.
- WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  level; starts fetching from IDLE.
- Stop  in  1  level; request to stop at the next instruction boundary.
- opcode  in  OPC_W  IR opcode field; valid from T3 onward.
- CON  in  1  branch condition from the CON flip-flop.
- mem_ready  in  1  memory read data valid.
- PCout, MARin, Read, MDRin, PCin, IncPC, MDRout, IRin  out  1 each  fetch and PC strobes.
- Gra, Rout, Rin, CONin, Yin, Zin, Cout, ZLOout  out  1 each  register-file and ALU strobes.
- LinkSel  out  1  forces R15 as the Rin target.
- AluAdd  out  1  ALU add select.
- step  out  4  current state code.
- busy  out  1  high in any state other than IDLE or HALTED.
- halted  out  1  high in HALTED.
- instr_done  out  1  one-cycle pulse on the final step of each instruction.
- illegal  out  1  one-cycle pulse in T3 on an unsupported opcode.
- mem_timeout  out  1  sticky flag; cleared only by Reset.

Behaviour:
- Outputs are Moore: decoded combinationally from the registered state, and asserted for the whole cycle. The only exceptions are the mem_ready, CON and opcode gating stated below.
- State codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALTED=8.
- Reset (asynchronous, any time, including mid-instruction): state goes to IDLE, wait counter to 0, mem_timeout to 0. All strobes, busy, halted, instr_done and illegal are 0.
- IDLE: no strobes. If Run=1, go to T0; otherwise stay in IDLE.
- T0: PCout, MARin. Go to T1.
- T1: Read and MDRin every cycle.
  - If mem_ready=1: PCin and IncPC are also asserted; go to T2; wait counter resets to 0.
  - If mem_ready=0: stay in T1 and increment the wait counter.
  - Timeout: if the counter equals MAX_WAIT while mem_ready=0, set mem_timeout and go to IDLE. PCin is not asserted, so PC is unchanged.
- T2: MDRout, IRin. Go to T3.
- T3: decode opcode.
  - JR_OPC: Gra, Rout, PCin; instr_done.
  - JAL_OPC: PCout, Rin, LinkSel (R15 <- PC+1); go to T4.
  - BR_OPC: Gra, Rout, CONin; go to T4.
  - NOP_OPC: instr_done.
  - HALT_OPC: instr_done; go to HALTED.
  - Any other opcode: illegal and instr_done.
- T4:
  - jal: Gra, Rout, PCin; instr_done.
  - br: PCout, Yin; go to T5.
- T5 (br only): Cout, AluAdd, Zin; go to T6.
- T6 (br only): ZLOout; PCin only if CON=1 in this cycle; instr_done.
- Instruction boundary: every step that asserts instr_done, except halt, goes to IDLE if Stop=1 in that cycle, otherwise to T0.
- Stop sampled at any other time has no effect.
- Run is ignored outside IDLE.
- HALTED: no strobes; halted=1; leaves only on Reset.
- Simultaneous Stop and halt: HALTED wins.
- Never assert two bus drivers (PCout, Rout, MDRout, ZLOout, Cout) in the same cycle; the verifier asserts this.

Test Plan:
1. jr R2: Run=1, opcode=10011, mem_ready=1 throughout. Expect the state sequence T0, T1, T2, T3, T0; PCin and IncPC asserted in T1; Gra, Rout and PCin asserted in T3; instr_done pulses in T3. With R2=25 in the datapath, PC=25 afterwards.
2. jal: opcode=10100, PC=13. Expect T3 to assert PCout, Rin and LinkSel, so R15 is written with 14. Expect T4 to assert Gra, Rout and PCin. Total of 5 cycles from T0.
3. Branch, taken and not taken: opcode=10010 run twice, with CON=1 in T6 and then CON=0 in T6. Expect PCin asserted in T6 only for the CON=1 case. Both cases take 7 cycles, T0 through T6.
4. Memory wait and timeout:
   - mem_ready low for 3 cycles, then high: T1 lasts 4 cycles, with PCin asserted only in the last.
   - mem_ready held low: after 16 T1 cycles, mem_timeout=1 and the state is IDLE.
5. Stop, halt and illegal:
   - Stop asserted during T2 of a jr: state returns to IDLE after T3.
   - opcode=11010: state goes to HALTED, halted=1, and Run is ignored.
   - opcode=00111: illegal pulses in T3.
6. Reset asserted mid-T5 of a branch, asynchronous to Clock: all outputs drop immediately and the state becomes IDLE. After Reset is released with Run=1, the sequencer refetches starting at T0.
